// File: rtl/binary_decoder_pkg.sv
// Shared constants and helpers for the binary decoder block.
package binary_decoder_pkg;

  localparam int unsigned DEF_IN_W  = 3;
  localparam int unsigned DEF_CNT_W = 8;

  // Widest one-hot vector the helper can build (select inputs up to 8 bits).
  localparam int unsigned ONEHOT_W = 256;

  // One-hot vector with bit idx set; callers truncate to their output width.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/binary_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module binary_decoder_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/binary_decoder.sv
// N-to-2^N one-hot decoder with a registered, valid-qualified copy and
// per-line saturating hit counters.
module binary_decoder
  import binary_decoder_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid,
  input  logic             cnt_clr,
  input  logic [IN_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CNT_W-1:0] counts [OUT_W];

  // Combinational decode; independent of clock, reset and valid.
  always_comb begin
    out = OUT_W'(onehot(32'(in)));
  end

  // Registered copy of the decode, updated only on valid inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

  // One hit counter per output line, bumped when that line is selected.
  for (genvar g = 0; g < OUT_W; g++) begin : g_cnt
    binary_decoder_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (in_valid && out[g]),
      .count(counts[g])
    );
  end

  // Read port shows the current (pre-increment) register value.
  always_comb begin
    cnt_out = counts[cnt_sel];
  end

endmodule

// File: tb/tb_binary_decoder.sv
// Directed plus randomized checks of binary_decoder against a simple model.
module tb_binary_decoder;
  import binary_decoder_pkg::*;

  localparam int IW   = 3;
  localparam int OW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] in;
  logic [OW-1:0] out;
  logic          in_valid;
  logic [OW-1:0] out_q;
  logic          out_valid;
  logic          cnt_clr;
  logic [IW-1:0] cnt_sel;
  logic [7:0]    cnt_out;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt [OW];
  int m_q;
  int m_valid;

  binary_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .in_valid (in_valid),
    .out_q    (out_q),
    .out_valid(out_valid),
    .cnt_clr  (cnt_clr),
    .cnt_sel  (cnt_sel),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < OW; i++) m_cnt[i] = 0;
    m_q     = 0;
    m_valid = 0;
  endtask

  // Advance one clock edge, updating the model with the inputs held at that edge.
  task automatic tick();
    @(posedge clk);
    m_valid = int'(in_valid);
    if (in_valid) m_q = 1 << int'(in);
    if (cnt_clr) begin
      for (int i = 0; i < OW; i++) m_cnt[i] = 0;
    end else if (in_valid && m_cnt[int'(in)] < CMAX) begin
      m_cnt[int'(in)] = m_cnt[int'(in)] + 1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"}, 32'(out), 32'(1 << int'(in)));
    check({tag, ".out_q"}, 32'(out_q), 32'(m_q));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".cnt_out"}, 32'(cnt_out), 32'(m_cnt[int'(cnt_sel)]));
  endtask

  initial begin
    rst      = 1'b1;
    in       = '0;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    cnt_sel  = '0;
    model_reset();

    // Combinational sweep, held in reset to show out ignores rst
    for (int i = 0; i < OW; i++) begin
      in = IW'(i);
      #10;
      check("sweep.out", 32'(out), 32'(1 << i));
    end
    for (int s = 0; s < OW; s++) begin
      cnt_sel = IW'(s);
      #1;
      check("reset.cnt_out", 32'(cnt_out), 32'd0);
    end
    check("reset.out_q", 32'(out_q), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);

    @(posedge clk);
    #3;
    rst = 1'b0;

    // Registered path
    in = 3'd3; in_valid = 1'b1;
    tick();
    check("reg.out_q", 32'(out_q), 32'h08);
    check("reg.out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; in = 3'd6;
    tick();
    check("hold.out_q", 32'(out_q), 32'h08);
    check("hold.out_valid", 32'(out_valid), 32'd0);
    check("hold.out", 32'(out), 32'h40);

    // Counters: 2, 2, 7
    in_valid = 1'b1;
    in = 3'd2; tick();
    in = 3'd2; tick();
    in = 3'd7; tick();
    in_valid = 1'b0;
    cnt_sel = 3'd2; #1; check("cnt.line2", 32'(cnt_out), 32'd2);
    cnt_sel = 3'd7; #1; check("cnt.line7", 32'(cnt_out), 32'd1);
    cnt_sel = 3'd0; #1; check("cnt.line0", 32'(cnt_out), 32'd0);
    cnt_sel = 3'd3; #1; check("cnt.line3", 32'(cnt_out), 32'd1);

    // Same-cycle read shows pre-increment value
    tick();
    in = 3'd7; in_valid = 1'b1; cnt_sel = 3'd7;
    #1; check("preinc.cnt_out", 32'(cnt_out), 32'd1);
    tick();
    check("postinc.cnt_out", 32'(cnt_out), 32'd2);

    // Saturation on line 1
    in = 3'd1; in_valid = 1'b1; cnt_sel = 3'd1;
    for (int i = 0; i < 300; i++) tick();
    check("sat.cnt_out", 32'(cnt_out), 32'd255);
    check_all("sat");

    // Clear beats a simultaneous increment
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    check("clr.cnt_out", 32'(cnt_out), 32'd0);
    check_all("clr");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in       = IW'($urandom_range(OW - 1));
      in_valid = 1'($urandom_range(3) != 0);
      cnt_clr  = 1'($urandom_range(40) == 0);
      cnt_sel  = IW'($urandom_range(OW - 1));
      #1;
      check("rnd.pre.cnt_out", 32'(cnt_out), 32'(m_cnt[int'(cnt_sel)]));
      tick();
      check_all("rnd");
    end
    cnt_clr = 1'b0;

    // Mid-stream async reset
    in = 3'd5; in_valid = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst.out_q", 32'(out_q), 32'd0);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    in = 3'd4;
    #1;
    check("midrst.out", 32'(out), 32'h10);
    for (int s = 0; s < OW; s++) begin
      cnt_sel = IW'(s);
      #0.5;
      check("midrst.cnt_out", 32'(cnt_out), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // First edge after release behaves normally
    in = 3'd4; in_valid = 1'b1; cnt_sel = 3'd4;
    tick();
    check("post_rst.out_q", 32'(out_q), 32'h10);
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
